// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one imem fetch at a time,
// hands instructions to decode and applies branch/jump redirects.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        decode_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign
);

    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [1:0]  state_reg;
    logic [31:0] pc_reg;
    logic        kill_reg;
    logic        redirect_misaligned;

    assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

    // A redirect in REQ suppresses the request so a stale address never transfers.
    assign imem_req  = (state_reg == REQ) && !redirect_valid;
    assign imem_addr = pc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= BOOT;
            pc_reg      <= RESET_PC;
            kill_reg    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= NOP;
            instr_pc    <= 32'h0000_0000;
            misalign    <= 1'b0;
        end else begin
            misalign <= 1'b0;
            case (state_reg)
                BOOT: state_reg <= REQ;
                REQ: begin
                    if (!redirect_valid && imem_ready) begin
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_reg || redirect_valid) begin
                            kill_reg  <= 1'b0;
                            state_reg <= REQ;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc_reg;
                            instr_valid <= 1'b1;
                            state_reg   <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        kill_reg <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_valid || decode_ready) begin
                        instr_valid <= 1'b0;
                        pc_reg      <= instr_pc + 32'd4;
                        state_reg   <= REQ;
                    end
                end
                default: state_reg <= BOOT;
            endcase
            // Redirect sits last so it overrides any pc update made above.
            if (redirect_valid) begin
                pc_reg   <= redirect_misaligned ? TRAP_VEC : redirect_pc;
                misalign <= redirect_misaligned;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer: one table row per clock cycle.
module tb_fetch_sequencer;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
    localparam logic [31:0] A0 = 32'h0010_0093;
    localparam logic [31:0] A1 = 32'h0020_0113;
    localparam logic [31:0] A2 = 32'h0030_0193;
    localparam logic [31:0] A3 = 32'h0040_0213;
    localparam logic [31:0] A4 = 32'h0050_0293;
    localparam logic [31:0] A5 = 32'h0060_0313;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        decode_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        misalign;

    int checks = 0;
    int failures = 0;

    fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .decode_ready(decode_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        dr;
        logic        rdv;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic        e_mis;
    } vec_t;

    vec_t tbl [0:33];

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rdata,
                                input logic dr, input logic rdv, input logic [31:0] rpc,
                                input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                                input logic [31:0] e_instr, input logic [31:0] e_ipc,
                                input logic e_mis);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.dr = dr; v.rdv = rdv; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv;
        v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
        end
    endtask

    task automatic check_outputs(input int row, input logic e_req, input logic [31:0] e_addr,
                                 input logic e_iv, input logic [31:0] e_instr,
                                 input logic [31:0] e_ipc, input logic e_mis);
        check("imem_req",    row, {31'h0, imem_req},    {31'h0, e_req});
        check("imem_addr",   row, imem_addr,            e_addr);
        check("instr_valid", row, {31'h0, instr_valid}, {31'h0, e_iv});
        check("instr",       row, instr,                e_instr);
        check("instr_pc",    row, instr_pc,             e_ipc);
        check("misalign",    row, {31'h0, misalign},    {31'h0, e_mis});
    endtask

    task automatic run_table(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            imem_ready     = tbl[i].rdy;
            imem_rvalid    = tbl[i].rv;
            imem_rdata     = tbl[i].rdata;
            decode_ready   = tbl[i].dr;
            redirect_valid = tbl[i].rdv;
            redirect_pc    = tbl[i].rpc;
            #1;
            check_outputs(i, tbl[i].e_req, tbl[i].e_addr, tbl[i].e_iv,
                          tbl[i].e_instr, tbl[i].e_ipc, tbl[i].e_mis);
            $display("row %0d: req=%0b addr=%h iv=%0b instr=%h ipc=%h mis=%0b",
                     i, imem_req, imem_addr, instr_valid, instr, instr_pc, misalign);
        end
    endtask

    initial begin
        // boot and three back-to-back fetches
        tbl[0]  = mk(1,0,32'h0,0,0,32'h0,     0,32'h0,0,NOP,32'h0,0);
        tbl[1]  = mk(1,0,32'h0,0,0,32'h0,     1,32'h0,0,NOP,32'h0,0);
        tbl[2]  = mk(1,1,A0,   0,0,32'h0,     0,32'h0,0,NOP,32'h0,0);
        tbl[3]  = mk(1,0,32'h0,1,0,32'h0,     0,32'h0,1,A0, 32'h0,0);
        tbl[4]  = mk(1,0,32'h0,0,0,32'h0,     1,32'h4,0,A0, 32'h0,0);
        tbl[5]  = mk(1,1,A1,   0,0,32'h0,     0,32'h4,0,A0, 32'h0,0);
        tbl[6]  = mk(1,0,32'h0,1,0,32'h0,     0,32'h4,1,A1, 32'h4,0);
        tbl[7]  = mk(1,0,32'h0,0,0,32'h0,     1,32'h8,0,A1, 32'h4,0);
        tbl[8]  = mk(1,1,A2,   0,0,32'h0,     0,32'h8,0,A1, 32'h4,0);
        // backpressure for 5 cycles; stray rvalid in HOLD must be ignored
        for (int i = 9; i <= 13; i++)
            tbl[i] = mk(1,1,JUNK,0,0,32'h0,   0,32'h8,1,A2, 32'h8,0);
        tbl[14] = mk(1,0,32'h0,1,0,32'h0,     0,32'h8,1,A2, 32'h8,0);
        // memory stall, then kill an in-flight fetch
        tbl[15] = mk(0,0,32'h0,0,0,32'h0,     1,32'hC,0,A2, 32'h8,0);
        tbl[16] = mk(1,0,32'h0,0,0,32'h0,     1,32'hC,0,A2, 32'h8,0);
        tbl[17] = mk(1,0,32'h0,0,1,32'h200,   0,32'hC,0,A2, 32'h8,0);
        tbl[18] = mk(1,0,32'h0,0,0,32'h0,     0,32'h200,0,A2,32'h8,0);
        tbl[19] = mk(1,0,32'h0,0,0,32'h0,     0,32'h200,0,A2,32'h8,0);
        tbl[20] = mk(1,1,JUNK, 0,0,32'h0,     0,32'h200,0,A2,32'h8,0);
        tbl[21] = mk(1,0,32'h0,0,0,32'h0,     1,32'h200,0,A2,32'h8,0);
        tbl[22] = mk(1,1,A3,   0,0,32'h0,     0,32'h200,0,A2,32'h8,0);
        // redirect together with decode_ready in HOLD
        tbl[23] = mk(1,0,32'h0,1,1,32'h40,    0,32'h200,1,A3,32'h200,0);
        tbl[24] = mk(1,0,32'h0,0,0,32'h0,     1,32'h40,0,A3, 32'h200,0);
        tbl[25] = mk(1,1,A4,   0,0,32'h0,     0,32'h40,0,A3, 32'h200,0);
        // misaligned redirect traps to TRAP_VEC
        tbl[26] = mk(1,0,32'h0,0,1,32'h102,   0,32'h40,1,A4, 32'h40,0);
        tbl[27] = mk(0,0,32'h0,0,0,32'h0,     1,32'h100,0,A4,32'h40,1);
        // redirect in REQ gates imem_req combinationally
        tbl[28] = mk(0,0,32'h0,0,1,32'hFFFF_FFFC, 0,32'h100,0,A4,32'h40,0);
        tbl[29] = mk(1,0,32'h0,0,0,32'h0,     1,32'hFFFF_FFFC,0,A4,32'h40,0);
        tbl[30] = mk(1,1,A5,   0,0,32'h0,     0,32'hFFFF_FFFC,0,A4,32'h40,0);
        tbl[31] = mk(1,0,32'h0,1,0,32'h0,     0,32'hFFFF_FFFC,1,A5,32'hFFFF_FFFC,0);
        // PC wraps to zero
        tbl[32] = mk(1,0,32'h0,0,0,32'h0,     1,32'h0,0,A5,32'hFFFF_FFFC,0);
        tbl[33] = mk(1,0,32'h0,0,0,32'h0,     0,32'h0,0,A5,32'hFFFF_FFFC,0);

        imem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs(-1, 1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b0);
        $display("reset state: req=%0b addr=%h iv=%0b instr=%h", imem_req, imem_addr,
                 instr_valid, instr);

        @(posedge clk);
        #2 rst_n = 1'b1;
        run_table(0, 33);

        // asynchronous reset while a fetch is outstanding
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_outputs(-2, 1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b0);
        $display("async reset in WAIT: req=%0b addr=%h iv=%0b instr=%h ipc=%h",
                 imem_req, imem_addr, instr_valid, instr, instr_pc);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        run_table(0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the RISC-V core. It owns the program-counter register and sequences one instruction-memory fetch at a time over a request/response handshake. It presents each fetched instruction to decode with a valid/ready handshake and applies branch/jump redirects, killing any in-flight fetch. The combinational next-PC logic supplies `redirect_valid`/`redirect_pc` and sits upstream. This block replaces the free-running PC register used in the single-cycle core.

## Interface

- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.
- `TRAP_VEC`, default `32'h0000_0100`: PC loaded on a misaligned redirect.

- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `imem_req`, output, 1: fetch request.
- `imem_addr`, output, 32: fetch address; equals `pc`.
- `imem_ready`, input, 1: memory accepts the request in this cycle.
- `imem_rvalid`, input, 1: response data valid.
- `imem_rdata`, input, 32: fetched instruction word.
- `instr_valid`, output, 1: instruction available to decode.
- `instr`, output, 32: instruction word.
- `instr_pc`, output, 32: address of `instr`.
- `decode_ready`, input, 1: decode consumes `instr` in this cycle.
- `redirect_valid`, input, 1: branch taken or jump; change control flow.
- `redirect_pc`, input, 32: redirect target.
- `misalign`, output, 1: one-cycle pulse when `redirect_pc[1:0]` is not 0.

## Operation

- Registers: `pc` (32 bits), `state`, `kill` (1 bit), `instr`, `instr_pc`, `instr_valid`, `misalign`.
- States:
  - BOOT: reset state. Lasts one cycle, then goes to REQ.
  - REQ: drives `imem_req`.
  - WAIT: one request is outstanding.
  - HOLD: holds an instruction for decode.
- Redirect load: `pc <= TRAP_VEC` and `misalign <= 1` if `redirect_pc[1:0] != 0`, else `pc <= redirect_pc`. Redirect has priority over every other `pc` update.
- BOOT:
  - `imem_req = 0`.
  - A redirect seen here is applied to `pc`.
- REQ:
  - `imem_req = !redirect_valid`. This is the only combinational path from an input to an output.
  - If `redirect_valid`: load the redirect and stay in REQ. No request is issued this cycle.
  - Else if `imem_ready`: request accepted; go to WAIT.
- WAIT:
  - `imem_rvalid && (kill || redirect_valid)`: discard the data, clear `kill`, apply any redirect, go to REQ.
  - `imem_rvalid` alone: latch `instr <= imem_rdata`, `instr_pc <= pc`, `instr_valid <= 1`; go to HOLD.
  - `redirect_valid` without `imem_rvalid`: load the redirect, set `kill`, stay in WAIT.
  - Repeated redirects while `kill` is set update `pc` only.
- HOLD:
  - `instr`, `instr_pc` and `instr_valid` stay stable until consumed.
  - `decode_ready` alone: `instr_valid <= 0`, `pc <= instr_pc + 4`, go to REQ.
  - `redirect_valid` (with or without `decode_ready`): `instr_valid <= 0`, load the redirect, go to REQ. If `decode_ready` was also high, the handshake counts as completed.
- At most one outstanding fetch. `imem_rvalid` outside WAIT is ignored.
- `pc + 4` is modulo 2^32: `32'hFFFF_FFFC` wraps to `32'h0000_0000`.

## Timing

- Reset values:
  - `pc = RESET_PC`, `state = BOOT`, `kill = 0`.
  - `imem_req = 0`, `imem_addr = RESET_PC`.
  - `instr_valid = 0`, `instr = 32'h0000_0013` (NOP), `instr_pc = 0`, `misalign = 0`.
- Asserting `rst_n` low mid-operation clears everything immediately. Any pending response is forgotten; the memory side must also be reset.
- First `imem_req` is in the second cycle after `rst_n` rises.
- A request transfers on a rising edge where `imem_req && imem_ready`. `imem_addr` is stable while `imem_req` is high and not accepted.
- `instr_valid` rises the cycle after `imem_rvalid`.
- Best case, with a zero-wait response and `decode_ready` held high: one instruction every 3 cycles (REQ, WAIT, HOLD).
- `misalign` is registered: high for exactly one cycle after the offending redirect.

## Test plan

- Reset/boot: release `rst_n` with `imem_ready=1` and a 1-cycle response -> first `imem_addr=0x0`. Fetched PCs are 0x0, 0x4, 0x8, one per 3 cycles. `instr` matches the memory contents.
- Backpressure: `decode_ready=0` for 5 cycles -> `instr_valid` stays high, `instr`/`instr_pc` stable, no new `imem_req`. Release -> next fetch at `instr_pc+4`.
- Kill in flight: `redirect_valid`, `redirect_pc=0x200` while in WAIT; response arrives 3 cycles later -> data discarded, `instr_valid` never rises, next `imem_addr=0x200`.
- Simultaneous events: `redirect_pc=0x40` in HOLD together with `decode_ready` -> instruction consumed once, next fetch at 0x40, not `instr_pc+4`.
- Misalign: `redirect_pc=0x102` -> `misalign` pulses one cycle, next fetch at `TRAP_VEC` (0x100).
- Wrap and reset: `pc=0xFFFFFFFC` consumed -> next fetch at 0x0. Assert `rst_n` low while in WAIT -> outputs immediately at reset values; after release, fetch restarts at `RESET_PC`.
